// File: rtl/twofish_kat_seq_if.sv
// Core-side bus between the KAT sequencer (master) and the twofish core (slave).
interface twofish_kat_seq_if #(
  parameter int DATA_W = 128
);
  logic              core_reset;
  logic [DATA_W-1:0] core_data_in;
  logic              core_button;
  logic [DATA_W-1:0] core_data_out;

  modport master (output core_reset, core_data_in, core_button, input core_data_out);
  modport slave  (input core_reset, core_data_in, core_button, output core_data_out);
endinterface

// File: rtl/twofish_kat_seq.sv
// Known-answer-test sequencer: per vector it resets the core, loads plaintext, holds
// button for a fixed latency, compares the result and accumulates a pass/fail summary.
module twofish_kat_seq #(
  parameter int DATA_W       = 128,
  parameter int NUM_VEC      = 4,
  parameter int IDX_W        = $clog2(NUM_VEC),
  parameter int RST_CYCLES   = 2,
  parameter int SETUP_CYCLES = 8,
  parameter int LATENCY      = 30,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [IDX_W-1:0]       vec_idx,
  input  logic [DATA_W-1:0]      vec_pt,
  input  logic [DATA_W-1:0]      vec_ct,
  twofish_kat_seq_if.master      core,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [IDX_W:0]         fail_count,
  output logic [IDX_W-1:0]       first_fail,
  output logic                   first_fail_valid
);

  localparam int CNT_M1  = (RST_CYCLES > SETUP_CYCLES) ? RST_CYCLES : SETUP_CYCLES;
  localparam int CNT_MAX = (CNT_M1 > LATENCY) ? CNT_M1 : LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(LATENCY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VEC - 1);
  localparam logic [IDX_W:0]   FAIL_MAX   = (IDX_W + 1)'(NUM_VEC);

  typedef enum logic [2:0] {
    S_IDLE, S_CORE_RST, S_LOAD, S_PRESS, S_CHECK, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   vec_idx_q, vec_idx_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic [DATA_W-1:0]  exp_q, exp_d;
  logic               core_reset_q, core_reset_d;
  logic               button_q, button_d;
  logic               mism_q, mism_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [IDX_W:0]     fail_cnt_q, fail_cnt_d;
  logic [IDX_W-1:0]   ff_q, ff_d;
  logic               ffv_q, ffv_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vec_idx_d    = vec_idx_q;
    din_d        = din_q;
    exp_d        = exp_q;
    core_reset_d = core_reset_q;
    button_d     = button_q;
    mism_d       = mism_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_cnt_d   = fail_cnt_q;
    ff_d         = ff_q;
    ffv_d        = ffv_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        core_reset_d = 1'b0;
        if (start) begin
          state_d      = S_CORE_RST;
          cnt_d        = '0;
          vec_idx_d    = '0;
          fail_cnt_d   = '0;
          ff_d         = '0;
          ffv_d        = 1'b0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          core_reset_d = 1'b1;
          button_d     = 1'b0;
        end
      end
      S_CORE_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d      = S_LOAD;
          cnt_d        = '0;
          din_d        = vec_pt;
          exp_d        = vec_ct;
          core_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (cnt_q == SETUP_LAST) begin
          state_d  = S_PRESS;
          cnt_d    = '0;
          button_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PRESS: begin
        if (cnt_q == LAT_LAST) begin
          state_d  = S_CHECK;
          cnt_d    = '0;
          button_d = 1'b0;
          mism_d   = (core.core_data_out != exp_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (mism_q) begin
          if (fail_cnt_q != FAIL_MAX) fail_cnt_d = fail_cnt_q + (IDX_W + 1)'(1);
          if (!ffv_q) begin
            ff_d  = vec_idx_q;
            ffv_d = 1'b1;
          end
        end
        // Summary is finalised on the same edge that raises done.
        if ((vec_idx_q == LAST_IDX) || (mism_q && STOP_ON_FAIL)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_cnt_d == '0);
        end else begin
          state_d      = S_CORE_RST;
          vec_idx_d    = vec_idx_q + IDX_W'(1);
          core_reset_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      vec_idx_q    <= '0;
      din_q        <= '0;
      core_reset_q <= 1'b1;
      button_q     <= 1'b0;
      mism_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_cnt_q   <= '0;
      ff_q         <= '0;
      ffv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vec_idx_q    <= vec_idx_d;
      din_q        <= din_d;
      core_reset_q <= core_reset_d;
      button_q     <= button_d;
      mism_q       <= mism_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_cnt_q   <= fail_cnt_d;
      ff_q         <= ff_d;
      ffv_q        <= ffv_d;
    end
  end

  // Expected value is pure data, only meaningful after a CORE_RST->LOAD capture.
  always_ff @(posedge clk) begin
    exp_q <= exp_d;
  end

  assign vec_idx           = vec_idx_q;
  assign core.core_reset   = core_reset_q;
  assign core.core_data_in = din_q;
  assign core.core_button  = button_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign pass              = pass_q;
  assign fail_count        = fail_cnt_q;
  assign first_fail        = ff_q;
  assign first_fail_valid  = ffv_q;

endmodule
